ts4231_pulse_capture: RTL and testbench



---
 rtl/ts4231_pkg.sv | 55 +++++
 rtl/ts4231_capture_fifo.sv | 49 ++++
 rtl/ts4231_pulse_capture.sv | 197 +++++++++++++++++++
 tb/tb_ts4231_pulse_capture.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts4231_pkg.sv
// ts4231_pkg: shared types and constants for the multi-sensor TS4231 capture.
// Holds channel states, the record layout helpers and 48 MHz tick defaults.
package ts4231_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    EVAL,
    STUCK
  } ch_state_t;

  localparam int DEF_CLK_FREQ_HZ = 48_000_000;

  // Tick divisors: 0.5 us glitch floor, 50 us sync floor,
  // ~417 us stuck-low limit.
  localparam int MIN_PULSE_DIV = 2_000_000;
  localparam int SYNC_MIN_DIV  = 20_000;
  localparam int MAX_PULSE_DIV = 2_400;

  function automatic int ticks(input int clk_hz, input int div);
    return clk_hz / div;
  endfunction

  localparam int DEF_MIN_PULSE_TICKS =
    DEF_CLK_FREQ_HZ / MIN_PULSE_DIV;
  localparam int DEF_SYNC_MIN_TICKS =
    DEF_CLK_FREQ_HZ / SYNC_MIN_DIV;
  localparam int DEF_MAX_PULSE_TICKS =
    DEF_CLK_FREQ_HZ / MAX_PULSE_DIV;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rec_w(
    input int n,
    input int pw,
    input int ts
  );
    return id_w(n) + 1 + pw + ts;
  endfunction

  localparam int DEF_ID_W = id_w(4);
  localparam int DEF_PW_W = 16;
  localparam int DEF_TS_W = 32;

  // Record layout at the default geometry (4 sensors, 16/32 bit fields).
  typedef struct packed {
    logic [DEF_ID_W-1:0] sensor_id;
    logic                is_sync;
    logic [DEF_PW_W-1:0] width;
    logic [DEF_TS_W-1:0] start_ts;
  } pulse_rec_t;

endpackage

// File: rtl/ts4231_capture_fifo.sv
// ts4231_capture_fifo: first-word-fall-through FIFO with occupancy output.
// Ports: push/push_data in, pop/rd_valid/rd_data out, level, full.
module ts4231_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [LW-1:0]    level,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_pop;
  logic             do_push;

  assign level    = wr_q - rd_q;
  assign rd_valid = (level != '0);
  assign full     = (level == LW'(DEPTH));
  assign rd_data  = mem[rd_q[AW-1:0]];

  assign do_pop  = rd_valid & pop;
  // A full FIFO still takes a write when the head leaves this cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ts4231_pulse_capture.sv
// ts4231_pulse_capture: per-sensor envelope timing, sync/sweep classing,
// round-robin merge into one record FIFO (rd_*), drop/stuck status.
module ts4231_pulse_capture
  import ts4231_pkg::*;
#(
  parameter int CLK_FREQ_HZ       = DEF_CLK_FREQ_HZ,
  parameter int NUMBER_OF_SENSORS = 4,
  parameter int TS_WIDTH          = 32,
  parameter int PW_WIDTH          = 16,
  parameter int FIFO_DEPTH        = 16,
  parameter int MIN_PULSE_TICKS   =
    ticks(CLK_FREQ_HZ, MIN_PULSE_DIV),
  parameter int SYNC_MIN_TICKS    =
    ticks(CLK_FREQ_HZ, SYNC_MIN_DIV),
  parameter int MAX_PULSE_TICKS   =
    ticks(CLK_FREQ_HZ, MAX_PULSE_DIV),
  parameter logic [TS_WIDTH-1:0] TS_INIT = '0,
  localparam int N     = NUMBER_OF_SENSORS,
  localparam int ID_W  = id_w(N),
  localparam int REC_W = rec_w(N, PW_WIDTH, TS_WIDTH),
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [N-1:0]     envelope_in,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [REC_W-1:0] rd_data,
  output logic [LVL_W-1:0] fifo_level,
  output logic [15:0]      drop_count,
  output logic [N-1:0]     stuck_flags
);

  localparam logic [TS_WIDTH-1:0] PW_MAX =
    TS_WIDTH'((64'd1 << PW_WIDTH) - 64'd1);

  logic [TS_WIDTH-1:0] ts_q;
  logic [N-1:0]        pend_vec;
  logic [N-1:0]        drop_vec;
  logic [N-1:0]        grant_vec;
  logic [REC_W-1:0]    pend_rec [N];
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     gnt_id;
  logic                gnt_any;
  logic                push;
  logic                fifo_full;
  logic [4:0]          ndrop;
  logic [16:0]         drop_sum;
  int                  arb_idx;

  always_ff @(posedge clock) begin
    if (!reset) ts_q <= TS_INIT;
    else        ts_q <= ts_q + TS_WIDTH'(1);
  end

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic                s1;
    logic                s2;
    logic                prev;
    ch_state_t           st;
    logic [TS_WIDTH-1:0] start;
    logic [PW_WIDTH-1:0] width;
    logic                pend;
    logic [REC_W-1:0]    rec;
    logic                stuck;
    logic [TS_WIDTH-1:0] elapsed;
    logic [PW_WIDTH-1:0] wsat;
    logic                fall;
    logic                rise;
    logic                keep;
    logic                is_sync;
    logic                load;

    assign fall    = prev & ~s2;
    assign rise    = ~prev & s2;
    assign elapsed = ts_q - start;
    assign wsat    = (elapsed > PW_MAX) ?
                     PW_WIDTH'(PW_MAX) : PW_WIDTH'(elapsed);
    assign keep    = (st == EVAL) & enable &
                     (width >= PW_WIDTH'(MIN_PULSE_TICKS));
    assign is_sync = (width >= PW_WIDTH'(SYNC_MIN_TICKS));
    assign load    = keep & ~pend;

    assign drop_vec[g]    = keep & pend;
    assign pend_vec[g]    = pend;
    assign pend_rec[g]    = rec;
    assign stuck_flags[g] = stuck;

    always_ff @(posedge clock) begin
      if (!reset) begin
        s1    <= 1'b1;
        s2    <= 1'b1;
        prev  <= 1'b1;
        st    <= IDLE;
        start <= '0;
        width <= '0;
        pend  <= 1'b0;
        rec   <= '0;
        stuck <= 1'b0;
      end else begin
        s1   <= envelope_in[g];
        s2   <= s1;
        prev <= s2;
        if (load) begin
          pend <= 1'b1;
          rec  <= {ID_W'(g), is_sync, width, start};
        end else if (grant_vec[g]) begin
          pend <= 1'b0;
        end
        if (!enable) begin
          st <= IDLE;
        end else begin
          unique case (st)
            IDLE: begin
              if (fall) begin
                start <= ts_q;
                st    <= LOW;
              end
            end
            LOW: begin
              // Width is frozen at the edge so EVAL sees the true low time.
              if (rise) begin
                width <= wsat;
                st    <= EVAL;
              end else if (elapsed > TS_WIDTH'(MAX_PULSE_TICKS)) begin
                stuck <= 1'b1;
                st    <= STUCK;
              end
            end
            EVAL:    st <= IDLE;
            STUCK:   if (s2) st <= IDLE;
            default: st <= IDLE;
          endcase
        end
      end
    end
  end

  // Round-robin: first pending slot at or after the pointer.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    arb_idx = 0;
    for (int i = 0; i < N; i++) begin
      arb_idx = int'(ptr_q) + i;
      if (arb_idx >= N) arb_idx = arb_idx - N;
      if (!gnt_any && pend_vec[arb_idx]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(arb_idx);
      end
    end
  end

  assign push      = gnt_any & ~fifo_full;
  assign grant_vec = push ? (N'(1) << gnt_id) : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (push) begin
      ptr_q <= (gnt_id == ID_W'(N - 1)) ?
               '0 : gnt_id + ID_W'(1);
    end
  end

  always_comb begin
    ndrop = '0;
    for (int i = 0; i < N; i++) begin
      ndrop = ndrop + {4'b0, drop_vec[i]};
    end
  end

  assign drop_sum = {1'b0, drop_count} + {12'b0, ndrop};

  always_ff @(posedge clock) begin
    if (!reset)           drop_count <= '0;
    else if (drop_sum[16]) drop_count <= 16'hFFFF;
    else                  drop_count <= drop_sum[15:0];
  end

  ts4231_capture_fifo #(
    .WIDTH(REC_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(pend_rec[gnt_id]),
    .pop      (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .level    (fifo_level),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_ts4231_pulse_capture.sv
// tb_ts4231_pulse_capture: vector table plus corner sequences for the
// multi-sensor pulse capture, records checked against a queue.
module tb_ts4231_pulse_capture;
  import ts4231_pkg::*;

  localparam logic [31:0] INIT = 32'hFFFF_FF9C;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [3:0]  envelope_in;
  logic        rd_valid;
  logic        rd_ready;
  logic [50:0] rd_data;
  logic [4:0]  fifo_level;
  logic [15:0] drop_count;
  logic [3:0]  stuck_flags;

  ts4231_pulse_capture #(
    .TS_INIT(INIT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .envelope_in(envelope_in),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .fifo_level (fifo_level),
    .drop_count (drop_count),
    .stuck_flags(stuck_flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference timestamp: value the DUT counter holds after each edge.
  logic [31:0] m_ts;
  always @(posedge clock) m_ts <= reset ? m_ts + 32'd1 : INIT;

  typedef struct {
    int ch;
    int w;
    bit rec;
    bit sync;
  } vec_t;

  vec_t       vecs [8];
  pulse_rec_t sb [$];
  int         tests;
  int         fails;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(
    input string      name,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic monitor();
    pulse_rec_t e;
    forever begin
      @(negedge clock);
      if (reset && rd_valid && rd_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL record_unexpected got=%0h exp=none",
                   rd_data);
        end else begin
          e = sb.pop_front();
          check("record", 64'(rd_data), 64'(e));
        end
      end
    end
  endtask

  task automatic expect_rec(
    input int          ch,
    input int          w,
    input bit          sync,
    input logic [31:0] st
  );
    pulse_rec_t r;
    r.sensor_id = 2'(ch);
    r.is_sync   = sync;
    r.width     = 16'(w);
    r.start_ts  = st;
    sb.push_back(r);
  endtask

  task automatic pulse(
    input int ch,
    input int w,
    input bit rec,
    input bit sync
  );
    logic [31:0] st;
    envelope_in[ch] = 1'b0;
    st = m_ts + 32'd2;
    step(w);
    envelope_in[ch] = 1'b1;
    if (rec) expect_rec(ch, w, sync, st);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    step(8);
    while ((sb.size() != 0 || rd_valid) && n < 200) begin
      step(1);
      n++;
    end
    check({name, "_left"}, 64'(sb.size()), 64'd0);
    check({name, "_level"}, 64'(fifo_level), 64'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st;
    vecs[0] = '{0, 300,   1'b1, 1'b0};
    vecs[1] = '{1, 3000,  1'b1, 1'b1};
    vecs[2] = '{2, 10,    1'b0, 1'b0};
    vecs[3] = '{3, 23,    1'b0, 1'b0};
    vecs[4] = '{0, 24,    1'b1, 1'b0};
    vecs[5] = '{1, 2399,  1'b1, 1'b0};
    vecs[6] = '{2, 2400,  1'b1, 1'b1};
    vecs[7] = '{3, 20000, 1'b1, 1'b1};
    tests = 0;
    fails = 0;
    reset = 1'b0;
    enable = 1'b0;
    envelope_in = 4'hF;
    rd_ready = 1'b1;
    fork
      monitor();
    join_none
    step(3);
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_stuck", 64'(stuck_flags), 64'd0);
    reset = 1'b1;
    enable = 1'b1;
    step(2);

    // Pulse straddling the timestamp wrap, with output latency.
    pulse(0, 200, 1'b1, 1'b0);
    step(4);
    check("lat_k3_valid", 64'(rd_valid), 64'd0);
    step(1);
    check("lat_k4_valid", 64'(rd_valid), 64'd1);
    check("lat_k4_level", 64'(fifo_level), 64'd1);
    wait_drain("wrap");

    for (int i = 0; i < 8; i++) begin
      pulse(vecs[i].ch, vecs[i].w, vecs[i].rec, vecs[i].sync);
      step(10);
      wait_drain("vec");
      check("vec_drop", 64'(drop_count), 64'd0);
    end

    // All four rise together: pushes on consecutive cycles, id order.
    rd_ready = 1'b0;
    envelope_in = 4'h0;
    st = m_ts + 32'd2;
    step(100);
    envelope_in = 4'hF;
    for (int c = 0; c < 4; c++) expect_rec(c, 100, 1'b0, st);
    step(4);
    check("simul_lvl0", 64'(fifo_level), 64'd0);
    for (int j = 1; j <= 4; j++) begin
      step(1);
      check("simul_lvl", 64'(fifo_level), 64'(j));
    end
    rd_ready = 1'b1;
    wait_drain("simul");

    // Pointer back at 0: ch0 must beat ch3.
    envelope_in = 4'h6;
    st = m_ts + 32'd2;
    step(50);
    envelope_in = 4'hF;
    expect_rec(0, 50, 1'b0, st);
    expect_rec(3, 50, 1'b0, st);
    wait_drain("ptr");

    // Overrun: 16 in FIFO, 1 pending, 3 dropped.
    rd_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pulse(0, 30, (i < 17), 1'b0);
      step(10);
    end
    step(10);
    check("ovr_level", 64'(fifo_level), 64'd16);
    check("ovr_drop", 64'(drop_count), 64'd3);
    rd_ready = 1'b1;
    wait_drain("ovr");
    check("ovr_drop_after", 64'(drop_count), 64'd3);

    // Stuck-low channel, then a normal pulse on it.
    envelope_in[3] = 1'b0;
    step(19000);
    check("stuck_early", 64'(stuck_flags), 64'd0);
    step(6000);
    check("stuck_set", 64'(stuck_flags), 64'h8);
    envelope_in[3] = 1'b1;
    step(10);
    wait_drain("stuck");
    pulse(3, 50, 1'b1, 1'b0);
    step(10);
    wait_drain("stuck_next");
    check("stuck_sticky", 64'(stuck_flags), 64'h8);

    // Enable dropped mid-pulse: the pulse is abandoned.
    envelope_in[1] = 1'b0;
    step(100);
    enable = 1'b0;
    step(3);
    enable = 1'b1;
    step(50);
    envelope_in[1] = 1'b1;
    wait_drain("enable");

    // Reset mid-operation with a record queued and a pulse open.
    rd_ready = 1'b0;
    pulse(0, 40, 1'b1, 1'b0);
    step(10);
    check("pre_rst_level", 64'(fifo_level), 64'd1);
    envelope_in[2] = 1'b0;
    step(50);
    reset = 1'b0;
    sb.delete();
    step(1);
    envelope_in[2] = 1'b1;
    step(1);
    check("mid_rst_valid", 64'(rd_valid), 64'd0);
    check("mid_rst_level", 64'(fifo_level), 64'd0);
    check("mid_rst_drop", 64'(drop_count), 64'd0);
    check("mid_rst_stuck", 64'(stuck_flags), 64'd0);
    reset = 1'b1;
    step(20);
    rd_ready = 1'b1;
    wait_drain("post_rst");
    pulse(1, 60, 1'b1, 1'b0);
    wait_drain("post_rst_pulse");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
